// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and default sizes for the multi-port register file.
package regfile_pkg;
   typedef enum logic {CLEAR, IDLE} seqState_t;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: walks every entry once after reset or a clear request, then idles.
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_req,
   output logic              ready,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);
   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
   seqState_t state;
   logic [ADDR_W:0] count;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= CLEAR;
         count <= '0;
         ready <= 1'b0;
      end else if (state == CLEAR) begin
         state <= count == LAST ? IDLE : CLEAR;
         ready <= count == LAST;
         count <= count == LAST ? '0 : count + 1'b1;
      end else if (clear_req) begin
         state <= CLEAR;
         count <= '0;
         ready <= 1'b0;
      end
   assign clr_we   = state == CLEAR;
   assign clr_addr = count[ADDR_W-1:0];
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: two-read/two-write register file with optional write bypass,
// hardware clear sequencer and per-register pending scoreboard.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter bit BYPASS   = 1'b1,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_req,
   output logic              ready,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   output logic              rd_pend_a,
   output logic              rd_pend_b,
   input  logic              wr_en0,
   input  logic              wr_en1,
   input  logic [ADDR_W-1:0] wr_addr0,
   input  logic [ADDR_W-1:0] wr_addr1,
   input  logic [DATA_W-1:0] wr_data0,
   input  logic [DATA_W-1:0] wr_data1,
   input  logic              pend_set,
   input  logic [ADDR_W-1:0] pend_addr
);
   localparam int DEPTH = 2**ADDR_W;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0] pend, clrMask, setMask;
   logic [ADDR_W-1:0] clrAddr;
   logic clrWe, we0, we1, setOk;

   regfile_clear_seq #(.ADDR_W(ADDR_W)) u_seq (
      .clk      (clk),
      .rst      (rst),
      .clear_req(clear_req),
      .ready    (ready),
      .clr_we   (clrWe),
      .clr_addr (clrAddr)
   );

   assign we0   = ready && wr_en0 && !(ZERO_REG && wr_addr0 == '0);
   assign we1   = ready && wr_en1 && !(ZERO_REG && wr_addr1 == '0);
   assign setOk = ready && pend_set && !(ZERO_REG && pend_addr == '0);

   // Port 1 is written last so it wins an address collision.
   always_ff @(posedge clk)
      if (clrWe) mem[clrAddr] <= '0;
      else begin
         if (we0) mem[wr_addr0] <= wr_data0;
         if (we1) mem[wr_addr1] <= wr_data1;
      end

   assign rd_data_a = !ready || (ZERO_REG && rd_addr_a == '0) ? '0 :
                      BYPASS && we1 && wr_addr1 == rd_addr_a ? wr_data1 :
                      BYPASS && we0 && wr_addr0 == rd_addr_a ? wr_data0 : mem[rd_addr_a];
   assign rd_data_b = !ready || (ZERO_REG && rd_addr_b == '0) ? '0 :
                      BYPASS && we1 && wr_addr1 == rd_addr_b ? wr_data1 :
                      BYPASS && we0 && wr_addr0 == rd_addr_b ? wr_data0 : mem[rd_addr_b];

   // A set landing on a register being written in the same cycle survives.
   assign clrMask = (we0 ? DEPTH'(1) << wr_addr0 : '0) | (we1 ? DEPTH'(1) << wr_addr1 : '0);
   assign setMask = setOk ? DEPTH'(1) << pend_addr : '0;
   always_ff @(posedge clk or negedge rst)
      if (!rst) pend <= '0;
      else pend <= clrWe ? '0 : (pend & ~clrMask) | setMask;

   assign rd_pend_a = ready && pend[rd_addr_a] && !(ZERO_REG && rd_addr_a == '0);
   assign rd_pend_b = ready && pend[rd_addr_b] && !(ZERO_REG && rd_addr_b == '0);
endmodule
